// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 NPC fetch path: FSM states,
// the nop encoding and the default reset PC.
package ysyx_25020047_pkg;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP,
    S_IDLE
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_25020047_IFU_slice.sv
// Output register stage towards decode: holds inst/pc/inst_fault stable
// while inst_valid is high and decode has not accepted.
module ysyx_25020047_IFU_slice
  import ysyx_25020047_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  input  logic        load_fault,
  input  logic        flush,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault
);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      pc         <= RESET_PC;
      inst_fault <= 1'b0;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst       <= load_inst;
      pc         <= load_pc;
      inst_fault <= load_fault;
    end else begin
      // A redirect both withdraws the held word and clears a pending fault.
      if (inst_valid && (inst_ready || flush))
        inst_valid <= 1'b0;
      if (flush)
        inst_fault <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_25020047_ifu.sv
// RV32 NPC instruction fetch unit: one outstanding word read, redirect with
// stale-response discard. Optional misaligned-redirect fault: IFU_MISALIGN_CHECK_EN.
module ysyx_25020047_ifu
  import ysyx_25020047_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] dnpc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic        inst_fault
);

  ifu_state_e  state, state_n;
  logic [31:0] fetch_pc, pc_n, tgt_pc;
  logic [31:0] ld_inst, ld_pc;
  logic        ld, ld_fault, go, req_fire;

`ifdef IFU_MISALIGN_CHECK_EN
  assign tgt_pc = dnpc;
`else
  assign tgt_pc = dnpc & 32'hFFFF_FFFC;
`endif

  assign req_fire = (state == S_REQ) && req_valid && req_ready;
  assign req_addr = fetch_pc;
  assign snpc     = seq_pc(pc);

  // 'go' means: start a fresh fetch at pc_n (or raise a fault instead).
  always_comb begin
    state_n  = state;
    pc_n     = redirect_valid ? tgt_pc : fetch_pc;
    ld       = 1'b0;
    ld_inst  = resp_data;
    ld_pc    = fetch_pc;
    ld_fault = 1'b0;
    go       = 1'b0;
    case (state)
      S_REQ: begin
        if (req_fire)
          state_n = redirect_valid ? S_DROP : S_WAIT;
        else if (redirect_valid)
          go = 1'b1;
      end
      S_WAIT: begin
        if (resp_valid) begin
          if (redirect_valid) begin
            go = 1'b1;
          end else begin
            ld      = 1'b1;
            state_n = S_OUT;
          end
        end else if (redirect_valid) begin
          state_n = S_DROP;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          go = 1'b1;
        end else if (inst_ready) begin
          pc_n = seq_pc(fetch_pc);
          if (halt)
            state_n = S_IDLE;
          else
            go = 1'b1;
        end
      end
      S_DROP: begin
        if (resp_valid)
          go = 1'b1;
      end
      S_IDLE: begin
        if (!halt)
          go = 1'b1;
      end
      default: state_n = S_REQ;
    endcase
`ifdef IFU_MISALIGN_CHECK_EN
    if (go && (pc_n[1:0] != 2'b00)) begin
      state_n  = S_OUT;
      ld       = 1'b1;
      ld_inst  = NOP_INST;
      ld_pc    = pc_n;
      ld_fault = 1'b1;
    end else if (go) begin
      state_n = S_REQ;
    end
`else
    if (go)
      state_n = S_REQ;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      req_valid <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= pc_n;
      req_valid <= (state_n == S_REQ);
    end
  end

  ysyx_25020047_IFU_slice #(
    .RESET_PC (RESET_PC)
  ) u_slice (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .load_inst  (ld_inst),
    .load_pc    (ld_pc),
    .load_fault (ld_fault),
    .flush      (redirect_valid),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .inst_fault (inst_fault)
  );

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Bench for ysyx_25020047_ifu: directed fetch/redirect/halt/reset steps, then
// randomized memory latency, stalls, halts and redirects against a PC-stream model.
module tb_ysyx_25020047_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, halt, redirect_valid;
  logic [31:0] dnpc;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc, snpc;
  logic        inst_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25020047_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .dnpc           (dnpc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .inst_fault     (inst_fault)
  );

  // Memory and decode-side model state
  bit          mem_busy   = 1'b0;
  logic [31:0] mem_data   = 32'h0;
  int          mem_lat    = 0;
  int          next_lat   = 0;
  bit          force_en   = 1'b0;
  logic [31:0] force_data = 32'h0;
  bit          rnd_mode   = 1'b0;
  logic [31:0] exp_pc     = RST_PC;
  int          hs_count   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] fix_target(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic misal(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: memory responds, decode model scores handshakes, then the edge.
  task automatic cycle();
    logic        acc, hs, stall, redir, rst_pre, flt;
    logic [31:0] a, p, i, d, dn;
    if (rnd_mode) begin
      req_ready      = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 2) != 0);
      halt           = ($urandom_range(0, 15) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      dnpc           = $urandom;
      next_lat       = $urandom_range(0, 3);
    end
    resp_valid = 1'b0;
    resp_data  = $urandom;
    if (mem_busy && mem_lat == 0) begin
      resp_valid = 1'b1;
      resp_data  = mem_data;
    end
    if (req_valid && !rst)
      chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
    acc     = req_valid && req_ready;
    a       = req_addr;
    hs      = inst_valid && inst_ready;
    p       = pc;
    i       = inst;
    d       = snpc;
    flt     = inst_fault;
    redir   = redirect_valid;
    dn      = dnpc;
    rst_pre = rst;
    stall   = inst_valid && !inst_ready && !redirect_valid && !rst;
    if (hs && !rst_pre) begin
      hs_count++;
      chk("hs_pc", p, exp_pc);
      chk("hs_snpc", d, p + 32'd4);
      if (!force_en)
        chk("hs_inst", i, misal(p) ? NOP : memf(p));
      chk("hs_fault", {31'd0, flt}, {31'd0, misal(p)});
      exp_pc = p + 32'd4;
    end
    if (redir && !rst_pre)
      exp_pc = fix_target(dn);
    tick();
    if (resp_valid)
      mem_busy = 1'b0;
    else if (mem_busy)
      mem_lat--;
    if (acc) begin
      mem_busy = 1'b1;
      mem_lat  = next_lat;
      mem_data = force_en ? force_data : memf(a);
    end
    if (stall) begin
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, i);
      chk("stall_pc", pc, p);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic wait_inst(input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_inst_timeout", {31'd0, inst_valid}, 32'd1);
  endtask

  initial begin
    int hs0;
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; dnpc = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; inst_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, RST_PC);
    chk("rst_snpc", snpc, RST_PC + 32'd4);
    chk("rst_fault", {31'd0, inst_fault}, 32'd0);
    chk("rst_req_addr", req_addr, RST_PC);

    // First fetch with zero-wait memory
    rst = 1'b0;
    chk("c0_req_valid", {31'd0, req_valid}, 32'd0);
    force_en = 1'b1; force_data = 32'h0010_0093; next_lat = 0; req_ready = 1'b1;
    cycle();
    chk("c1_req_valid", {31'd0, req_valid}, 32'd1);
    chk("c1_req_addr", req_addr, RST_PC);
    cycle();
    chk("c2_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("c2_req_valid", {31'd0, req_valid}, 32'd0);
    cycle();
    chk("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("c3_inst", inst, 32'h0010_0093);
    chk("c3_pc", pc, RST_PC);
    chk("c3_snpc", snpc, 32'h8000_0004);

    // Decode stall for 5 cycles
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h0010_0093);
      chk("hold_pc", pc, RST_PC);
      chk("hold_no_req", {31'd0, req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    force_en = 1'b0;
    chk("after_hs_valid", {31'd0, inst_valid}, 32'd0);
    chk("after_hs_req", {31'd0, req_valid}, 32'd1);
    chk("after_hs_addr", req_addr, 32'h8000_0004);

    // Redirect after acceptance; stale DEAD_BEEF arrives 4 cycles after acceptance
    next_lat = 3; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    cycle();
    redirect_valid = 1'b1; dnpc = 32'h8000_0100;
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("drop_no_inst", {31'd0, inst_valid}, 32'd0);
      chk("drop_no_req", {31'd0, req_valid}, 32'd0);
      cycle();
    end
    chk("drop_req_valid", {31'd0, req_valid}, 32'd1);
    chk("drop_req_addr", req_addr, 32'h8000_0100);
    chk("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    force_en = 1'b0; next_lat = 0;

    // Redirect in the same cycle as an OUT handshake
    wait_inst(10);
    chk("redir_inst", inst, memf(32'h8000_0100));
    chk("redir_pc", pc, 32'h8000_0100);
    inst_ready = 1'b1; redirect_valid = 1'b1; dnpc = 32'h8000_0200;
    cycle();
    inst_ready = 1'b0;
    chk("redir_hs_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_hs_req", {31'd0, req_valid}, 32'd1);
    chk("redir_hs_addr", req_addr, 32'h8000_0200);

    // Halt at the OUT handshake
    wait_inst(10);
    halt = 1'b1; inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("halt_no_req", {31'd0, req_valid}, 32'd0);
      cycle();
    end
    halt = 1'b0;
    cycle();
    chk("unhalt_req", {31'd0, req_valid}, 32'd1);
    chk("unhalt_addr", req_addr, 32'h8000_0204);

    // Misaligned redirect while a request is pending but not accepted
    req_ready = 1'b0; redirect_valid = 1'b1; dnpc = 32'h8000_0102;
    cycle();
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_no_req", {31'd0, req_valid}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_fault", {31'd0, inst_fault}, 32'd1);
    chk("mis_pc", pc, 32'h8000_0102);
    chk("mis_inst", inst, NOP);
`else
    chk("mis_req", {31'd0, req_valid}, 32'd1);
    chk("mis_addr", req_addr, 32'h8000_0100);
    chk("mis_fault", {31'd0, inst_fault}, 32'd0);
`endif

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; dnpc = 32'hFFFF_FFFC;
    cycle();
    chk("wrap_fault_clr", {31'd0, inst_fault}, 32'd0);
    chk("wrap_req", {31'd0, req_valid}, 32'd1);
    chk("wrap_addr", req_addr, 32'hFFFF_FFFC);
    req_ready = 1'b1;
    wait_inst(10);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_snpc", snpc, 32'h0000_0000);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    chk("wrap_next_req", {31'd0, req_valid}, 32'd1);
    chk("wrap_next_addr", req_addr, 32'h0000_0000);

    // Reset mid-transaction; the late response must be ignored
    next_lat = 1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("mrst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("mrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mrst_pc", pc, RST_PC);
    chk("mrst_inst", inst, NOP);
    chk("mrst_addr", req_addr, RST_PC);
    rst = 1'b0;
    exp_pc = RST_PC;
    cycle();
    chk("late_resp_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_resp_req", {31'd0, req_valid}, 32'd1);
    chk("late_resp_addr", req_addr, RST_PC);

    // Randomized traffic against the PC-stream model
    rnd_mode = 1'b1;
    hs0 = hs_count;
    for (int k = 0; k < 2000; k++)
      cycle();
    rnd_mode = 1'b0;
    halt = 1'b0;
    chk("liveness", {31'd0, (hs_count - hs0) > 30}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_ifu.md
# ysyx_25020047_ifu

Instruction fetch unit for the RV32 NPC core, the producing end of the instruction interface that the decode stage consumes. Holds the architectural fetch PC, issues one word read per instruction on a valid/ready memory request channel, and presents the fetched word plus its PC to decode on a valid/ready handshake. Takes `dnpc` redirects from the execute/writeback path and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h8000_0000, fetch PC loaded on reset
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `halt`  in  1  level; when high, no new memory request is started (ebreak stop)
- `redirect_valid`  in  1  one-cycle pulse: next fetch goes to `dnpc`
- `dnpc`  in  32  redirect target
- `req_valid`  out  1  memory read request
- `req_ready`  in  1  memory accepts request
- `req_addr`  out  32  word address of request
- `resp_valid`  in  1  read data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- `resp_data`  in  32  read data
- `inst_valid`  out  1  instruction available to decode
- `inst_ready`  in  1  decode accepts instruction
- `inst`  out  32  instruction word
- `pc`  out  32  PC of `inst`
- `snpc`  out  32  `pc + 4`
- `inst_fault`  out  1  misaligned-fetch marker (see Configuration)

## Operation
- FSM states: REQ, WAIT, OUT, DROP, IDLE.
- REQ: `req_valid`=1, `req_addr`=fetch PC. On `req_ready` → WAIT.
- WAIT: on `resp_valid` capture `resp_data` into `inst` → OUT.
- OUT: `inst_valid`=1, `inst`/`pc` held stable until `inst_ready`. On handshake fetch PC ← `pc+4` → REQ (or IDLE if `halt`).
- IDLE: no request; leaves to REQ when `halt` low.
- DROP: wait for the one outstanding response, discard it, → REQ at redirected PC.
- Redirect (fetch PC ← `dnpc`), by state:
  - REQ without `req_ready` this cycle → stay REQ with the new address (request withdrawn; the memory side tolerates a withdrawn request).
  - REQ with `req_ready` same cycle → DROP.
  - WAIT without `resp_valid` → DROP.
  - WAIT with `resp_valid` same cycle → response discarded → REQ.
  - OUT → `inst_valid` drops the next cycle → REQ. If `inst_ready` is in the same cycle, the instruction counts as consumed, but `dnpc` wins over `pc+4`.
  - DROP → target updated, stay DROP.
  - IDLE → target updated, stay IDLE.
- `halt` checked only when leaving OUT or in IDLE. It never aborts an outstanding request.
- `resp_valid` while in REQ/OUT/IDLE is a protocol violation and is ignored.
- All PC arithmetic is modulo 2^32: `32'hFFFF_FFFC + 4` wraps to 0.

## Timing
- Reset values: state=REQ, fetch PC=`RESET_PC`, `req_valid`=0 during reset, `inst_valid`=0, `inst`=32'h0000_0013 (nop), `pc`=`RESET_PC`, `inst_fault`=0.
- First `req_valid` is in the first cycle after `rst` deasserts.
- Minimum fetch latency with zero-wait memory: request accepted in cycle N, response in N+1, `inst_valid` in N+2.
- One instruction at most every 3 cycles; one outstanding request maximum.
- `req_valid`, `req_addr`, `inst_valid`, `inst`, `pc` are registered; `snpc` is combinational from `pc`.
- Reset mid-transaction returns to the reset state immediately. A late response after reset is ignored, because its state is not WAIT.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A redirect with `dnpc[1:0]≠0` issues no request.
  - The FSM goes to OUT with `inst`=nop, `pc`=`dnpc`, `inst_fault`=1.
  - The next redirect then clears the fault.
- `IFU_MISALIGN_CHECK_EN` undefined:
  - `dnpc[1:0]` is forced to 0.
  - `inst_fault` is tied to 0.

## Structure
- Shared package `ysyx_25020047_pkg` holds:
  - the FSM state enum,
  - `NOP_INST` = 32'h0000_0013,
  - the default `RESET_PC`.
- One sub-module is natural: `ysyx_25020047_IFU_slice`, the output register stage (`inst`, `pc`, `inst_fault`, valid/ready hold).

## Test plan
- Reset release, zero-wait memory returning 32'h0010_0093 → `req_addr`=8000_0000 at cycle 1, `inst_valid` at cycle 3 with `pc`=8000_0000, `snpc`=8000_0004.
- Decode holds `inst_ready`=0 for 5 cycles → `inst`/`pc` stable, no new `req_valid`; the next request after the handshake is to 8000_0004.
- Redirect to 8000_0100 one cycle after request acceptance, old response 32'hDEAD_BEEF arrives 4 cycles later → response discarded, next `req_addr`=8000_0100, no `inst_valid` for DEAD_BEEF.
- Redirect in the same cycle as an OUT handshake → next `req_addr`=`dnpc`, not `pc+4`.
- `halt`=1 while in OUT → after the handshake `req_valid` stays 0. Releasing `halt` → request to `pc+4`.
- With `IFU_MISALIGN_CHECK_EN`, redirect to 8000_0102 → no request, `inst_valid`=1, `inst_fault`=1, `pc`=8000_0102. Without it → `req_addr`=8000_0100.
